// File: rtl/memory_reader_pkg.sv
// Shared types and constants for the program-RAM read-back monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memory_reader_pkg;

   // Read sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   // Auto-scan period on the board clock, and a short one for simulation
   localparam logic [23:0] SCAN_DIV_DEFAULT = 24'd5_000_000;
   localparam logic [23:0] SCAN_DIV_SIM     = 24'd8;

endpackage

// File: rtl/memory_reader_btn_edge_sync.sv
// Two-flop synchronizer for an active-low button plus a one-clock falling-edge pulse.
// Latency: pulse appears 2 clocks after the level falls (sync depth), one pulse per press.
// Backpressure: none; the pulse is fire-and-forget, the consumer must latch it if busy.
// Ports: clock/reset (sync, active-high); btn_n raw async level; fall_pulse one-clock strobe.
module btn_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic btn_n,
   output logic fall_pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // All flops reset high so a released button never looks like a press
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_1    <= btn_n;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign fall_pulse = sync_prev & ~sync_2;

endmodule

// File: rtl/memory_reader.sv
// Walks program RAM one address per step (button or auto-scan), shows adrs/data, keeps a checksum.
// Latency: ISSUE, WAIT (RD_LAT clocks), CAPTURE; shown_* update at the end of CAPTURE.
// Backpressure: a step while busy is held as one pending request; further requests are dropped.
// Ports: clock/reset; step_btn (active-low raw), load/start_adrs, auto_en; RAM side adrs_out,
//        rd_en_out, q_in; monitor side shown_adrs, shown_data, valid_out, checksum_out, wrap_out.
module memory_reader
   import memory_reader_pkg::*;
#(
   parameter int          ADRS_W   = 8,
   parameter int          DATA_W   = 8,
   parameter int          RD_LAT   = 1,
   parameter logic [23:0] SCAN_DIV = SCAN_DIV_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              step_btn,
   input  logic              load,
   input  logic [ADRS_W-1:0] start_adrs,
   input  logic              auto_en,
   output logic [ADRS_W-1:0] adrs_out,
   output logic              rd_en_out,
   input  logic [DATA_W-1:0] q_in,
   output logic [ADRS_W-1:0] shown_adrs,
   output logic [DATA_W-1:0] shown_data,
   output logic              valid_out,
   output logic [DATA_W-1:0] checksum_out,
   output logic              wrap_out
);

   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        wait_cnt;
   logic [ADRS_W-1:0] next_adrs;
   logic              pending;
   logic [23:0]       scan_cnt;
   logic              scan_tick;
   logic              btn_step;
   logic              step_req;

   btn_edge_sync u_btn (
      .clock      (clock),
      .reset      (reset),
      .btn_n      (step_btn),
      .fall_pulse (btn_step)
   );

   // Auto-scan divider: held at 0 whenever auto mode is off
   assign scan_tick = auto_en && (scan_cnt == SCAN_DIV - 24'd1);

   always_ff @(posedge clock) begin
      if (reset || !auto_en) begin
         scan_cnt <= '0;
      end else if (scan_tick) begin
         scan_cnt <= '0;
      end else begin
         scan_cnt <= scan_cnt + 24'd1;
      end
   end

   // load masks all step sources so a press during load cannot start a read
   assign step_req = (auto_en ? scan_tick : btn_step) & ~load;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (step_req || pending) state_nxt = ST_ISSUE;
         ST_ISSUE:   state_nxt = ST_WAIT;
         ST_WAIT:    if (wait_cnt == 2'd0) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (load) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         next_adrs    <= '0;
         pending      <= 1'b0;
         adrs_out     <= '0;
         shown_adrs   <= '0;
         shown_data   <= '0;
         valid_out    <= 1'b0;
         checksum_out <= '0;
      end else if (load) begin
         state        <= ST_IDLE;
         next_adrs    <= start_adrs;
         pending      <= 1'b0;
         valid_out    <= 1'b0;
         checksum_out <= '0;
      end else begin
         state <= state_nxt;

         // IDLE consumes any pending step; elsewhere a step is remembered once
         if (state == ST_IDLE) begin
            pending <= 1'b0;
         end else if (step_req) begin
            pending <= 1'b1;
         end

         case (state)
            ST_ISSUE: begin
               adrs_out <= next_adrs;
               wait_cnt <= WAIT_INIT;
            end
            ST_WAIT: begin
               if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
            end
            ST_CAPTURE: begin
               shown_adrs   <= adrs_out;
               shown_data   <= q_in;
               valid_out    <= 1'b1;
               checksum_out <= checksum_out + q_in;
               // Natural modulo wrap takes the all-ones address back to 0
               next_adrs    <= adrs_out + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_en_out = (state != ST_IDLE);
   assign wrap_out  = (state == ST_CAPTURE) && (adrs_out == '1) && !load;

endmodule

// File: tb/tb_memory_reader.sv
module tb_memory_reader;
   import memory_reader_pkg::*;

   logic       clock = 1'b0;
   logic       reset;

   // DUT with single-cycle RAM
   logic       btn, load, auto_en;
   logic [7:0] start_adrs, adrs, q, sh_adrs, sh_data, cs;
   logic       rd_en, valid, wrap;

   // DUT with three-cycle RAM
   logic       btn3, load3;
   logic       auto3;
   logic [7:0] start3, adrs3, q3, sh_adrs3, sh_data3, cs3;
   logic       rd_en3, valid3, wrap3;
   logic [7:0] p1, p2;

   int checks = 0;
   int errors = 0;

   int wrap_cnt = 0, wrap_bad = 0;
   int rd3_rises = 0, stab_viol = 0, rd3_idx = 0;
   logic       rd_en3_q = 1'b0;
   logic [7:0] adrs3_ref = 8'h00;

   assign auto3 = 1'b0;

   always #5 clock = ~clock;

   memory_reader #(.ADRS_W(8), .DATA_W(8), .RD_LAT(1), .SCAN_DIV(SCAN_DIV_SIM)) dut (
      .clock(clock), .reset(reset), .step_btn(btn), .load(load), .start_adrs(start_adrs),
      .auto_en(auto_en), .adrs_out(adrs), .rd_en_out(rd_en), .q_in(q),
      .shown_adrs(sh_adrs), .shown_data(sh_data), .valid_out(valid),
      .checksum_out(cs), .wrap_out(wrap));

   memory_reader #(.ADRS_W(8), .DATA_W(8), .RD_LAT(3), .SCAN_DIV(SCAN_DIV_SIM)) dut3 (
      .clock(clock), .reset(reset), .step_btn(btn3), .load(load3), .start_adrs(start3),
      .auto_en(auto3), .adrs_out(adrs3), .rd_en_out(rd_en3), .q_in(q3),
      .shown_adrs(sh_adrs3), .shown_data(sh_data3), .valid_out(valid3),
      .checksum_out(cs3), .wrap_out(wrap3));

   function automatic logic [7:0] mem_rd(input logic [7:0] a);
      return a ^ 8'h5A;
   endfunction

   // RAM models: 1-cycle and 3-cycle registered read
   always @(posedge clock) begin
      q  <= mem_rd(adrs);
      p1 <= mem_rd(adrs3);
      p2 <= p1;
      q3 <= p2;
   end

   // Monitors sampled on the falling edge
   always @(negedge clock) begin
      if (wrap) begin
         wrap_cnt++;
         if (!(rd_en && adrs == 8'hFF)) wrap_bad++;
      end
      if (rd_en3 && !rd_en3_q) rd3_rises++;
      rd_en3_q = rd_en3;
      if (rd_en3) begin
         if (rd3_idx == 1) adrs3_ref = adrs3;
         else if (rd3_idx > 1 && adrs3 != adrs3_ref) stab_viol++;
         rd3_idx++;
      end else begin
         rd3_idx = 0;
      end
      if (wrap3) wrap_bad++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input bit which);
      if (which) btn3 = 1'b0; else btn = 1'b0;
      repeat (3) tick();
      if (which) btn3 = 1'b1; else btn = 1'b1;
      repeat (8) tick();
   endtask

   task automatic wait_rd(input bit which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if ((which ? rd_en3 : rd_en) == 1'b1) ok = 1'b1;
         else tick();
      end
   endtask

   typedef struct {
      bit         do_load;
      logic [7:0] start;
      int         presses;
      logic [7:0] exp_adrs;
      logic [7:0] exp_data;
      logic [7:0] exp_cs;
      int         exp_wraps;
   } vec_t;

   vec_t vecs[3];

   initial begin
      bit ok;
      int w0, r0, v0;

      vecs[0] = '{1'b0, 8'h00, 2, 8'h12, 8'h48, 8'hDD, 0};
      vecs[1] = '{1'b1, 8'hFE, 3, 8'h00, 8'h5A, 8'hA3, 1};
      vecs[2] = '{1'b1, 8'h20, 1, 8'h20, 8'h7A, 8'h7A, 0};

      reset = 1'b1; btn = 1'b1; load = 1'b0; auto_en = 1'b0; start_adrs = 8'h00;
      btn3 = 1'b1; load3 = 1'b0; start3 = 8'h00;
      repeat (3) tick();
      chk("rst_adrs", 32'(adrs), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_shown_adrs", 32'(sh_adrs), 0);
      chk("rst_shown_data", 32'(sh_data), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_checksum", 32'(cs), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst3_rd_en", 32'(rd_en3), 0);
      reset = 1'b0;
      tick();

      // First step after load reads start_adrs; shown 3 clocks after the read starts
      start_adrs = 8'h10; load = 1'b1; tick(); load = 1'b0; tick();
      btn = 1'b0;
      wait_rd(1'b0, ok);
      chk("first_rd_timeout", 32'(ok), 1);
      repeat (2) tick();
      chk("lat_valid_early", 32'(valid), 0);
      tick();
      chk("lat_valid", 32'(valid), 1);
      chk("lat_shown_adrs", 32'(sh_adrs), 32'h10);
      chk("lat_shown_data", 32'(sh_data), 32'h4A);
      chk("lat_checksum", 32'(cs), 32'h4A);
      btn = 1'b1;
      repeat (5) tick();

      for (int i = 0; i < 3; i++) begin
         w0 = wrap_cnt;
         if (vecs[i].do_load) begin
            start_adrs = vecs[i].start; load = 1'b1; tick();
            chk("vec_load_valid", 32'(valid), 0);
            chk("vec_load_checksum", 32'(cs), 0);
            load = 1'b0; tick();
         end
         for (int p = 0; p < vecs[i].presses; p++) press(1'b0);
         chk("vec_shown_adrs", 32'(sh_adrs), 32'(vecs[i].exp_adrs));
         chk("vec_shown_data", 32'(sh_data), 32'(vecs[i].exp_data));
         chk("vec_checksum", 32'(cs), 32'(vecs[i].exp_cs));
         chk("vec_valid", 32'(valid), 1);
         chk("vec_wraps", 32'(wrap_cnt - w0), 32'(vecs[i].exp_wraps));
      end
      chk("wrap_placement", 32'(wrap_bad), 0);

      // Auto-scan: one capture every 8 clocks, button ignored
      start_adrs = 8'h00; load = 1'b1; tick(); load = 1'b0; tick();
      auto_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (valid && sh_adrs == 8'h00) ok = 1'b1;
         else tick();
      end
      chk("auto_first_timeout", 32'(ok), 1);
      for (int k = 1; k <= 3; k++) begin
         if (k == 2) begin
            repeat (3) tick(); btn = 1'b0; repeat (2) tick(); btn = 1'b1; repeat (2) tick();
         end else begin
            repeat (7) tick();
         end
         chk("auto_hold", 32'(sh_adrs), 32'(k - 1));
         tick();
         chk("auto_step", 32'(sh_adrs), 32'(k));
      end
      chk("auto_checksum", 32'(cs), 32'h66);
      auto_en = 1'b0;
      repeat (10) tick();

      // RD_LAT=3: three requests 2 clocks apart -> one read, one pending, one dropped
      start3 = 8'h50; load3 = 1'b1; tick(); load3 = 1'b0; tick();
      r0 = rd3_rises; v0 = stab_viol;
      for (int k = 0; k < 3; k++) begin
         btn3 = 1'b0; tick(); btn3 = 1'b1; tick();
      end
      repeat (25) tick();
      chk("pend_reads", 32'(rd3_rises - r0), 2);
      chk("pend_adrs_stable", 32'(stab_viol - v0), 0);
      chk("pend_shown_adrs", 32'(sh_adrs3), 32'h51);
      chk("pend_shown_data", 32'(sh_data3), 32'h0B);
      chk("pend_checksum", 32'(cs3), 32'h15);

      // load during WAIT aborts the read and clears the monitor
      btn3 = 1'b0;
      wait_rd(1'b1, ok);
      chk("wait_rd_timeout", 32'(ok), 1);
      repeat (2) tick();
      chk("in_wait_rd_en", 32'(rd_en3), 1);
      start3 = 8'h40; load3 = 1'b1; tick();
      chk("abort_valid", 32'(valid3), 0);
      chk("abort_checksum", 32'(cs3), 0);
      load3 = 1'b0; btn3 = 1'b1;
      repeat (12) tick();
      chk("abort_no_capture", 32'(valid3), 0);
      press(1'b1);
      repeat (4) tick();
      chk("after_abort_adrs", 32'(sh_adrs3), 32'h40);
      chk("after_abort_data", 32'(sh_data3), 32'h1A);
      chk("after_abort_cs", 32'(cs3), 32'h1A);

      // reset during CAPTURE
      btn = 1'b0;
      wait_rd(1'b0, ok);
      chk("cap_rd_timeout", 32'(ok), 1);
      repeat (2) tick();
      chk("in_capture_rd_en", 32'(rd_en), 1);
      reset = 1'b1; tick();
      chk("mid_rst_adrs", 32'(adrs), 0);
      chk("mid_rst_rd_en", 32'(rd_en), 0);
      chk("mid_rst_shown_adrs", 32'(sh_adrs), 0);
      chk("mid_rst_shown_data", 32'(sh_data), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_checksum", 32'(cs), 0);
      chk("mid_rst_wrap", 32'(wrap), 0);
      btn = 1'b1; reset = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_reader.md
Name: memory_reader

Overview:
- Read-back counterpart to the memory programmer. Walks the program RAM one address at a time, either on a push-button step or on an auto-scan timer.
- Each step issues a read, captures the returned byte and presents the address/data pair to the 7-seg debug monitor. Also keeps a running 8-bit checksum so the operator can verify a loaded program.
- Sits in the shell between the RAM read port and the sseg decoders. Owns the RAM address mux input while the shell is in dump mode.

Parameters:
- ADRS_W, 8, address width
- DATA_W, 8, data width
- RD_LAT, 1, clocks from adrs_out change to q_in valid (synchronous RAM = 1); legal range 1..3
- SCAN_DIV, 24'd5_000_000, clocks between auto-scan steps (≥ RD_LAT+3)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- step_btn  in  1  raw push-button level, active-low, asynchronous to clock
- load  in  1  level; while high, start_adrs is loaded and the checksum cleared
- start_adrs  in  ADRS_W  first address to dump
- auto_en  in  1  1 = auto-scan, step_btn ignored
- adrs_out  out  ADRS_W  RAM read address
- rd_en_out  out  1  high while a read is in flight
- q_in  in  DATA_W  RAM read data
- shown_adrs  out  ADRS_W  address of the displayed byte
- shown_data  out  DATA_W  displayed byte
- valid_out  out  1  shown_* hold a captured value
- checksum_out  out  DATA_W  mod-2^DATA_W sum of bytes captured since last load/reset
- wrap_out  out  1  one-clock pulse when the address advances 0xFF→0x00

Behaviour:
- Reset values: all outputs 0; state IDLE; internal next-address register = 0; pending = 0; sync flops = 1 (button released).
- Button input:
  - 2-flop synchronizer, then falling-edge detect produces step_req, one pulse per press.
  - No debounce in this block; the shell supplies debounced buttons.
- Auto mode: free-running divider; step_req pulses when the divider reaches SCAN_DIV-1, then it reloads to 0. The divider is held at 0 while auto_en = 0.
- State machine IDLE → ISSUE → WAIT → CAPTURE → IDLE:
  - IDLE: on step_req (or pending = 1) go to ISSUE and clear pending.
  - ISSUE, 1 clock: adrs_out ← next address, rd_en_out = 1, wait counter ← RD_LAT-1.
  - WAIT: hold adrs_out; decrement the counter; at 0 go to CAPTURE. rd_en_out stays 1.
  - CAPTURE, 1 clock: shown_adrs ← adrs_out, shown_data ← q_in, valid_out ← 1, checksum += q_in (truncate), next address ← adrs_out+1.
  - If adrs_out = 0xFF in CAPTURE, wrap_out = 1 for that clock and the next address becomes 0x00.
  - rd_en_out = 0 on exit from CAPTURE.
- Latency: with RD_LAT = 1, step_req to valid shown_* = 3 clocks (ISSUE, WAIT, CAPTURE; registered outputs update at the end of CAPTURE).
- Step while busy: a step_req arriving outside IDLE sets pending. Only one pending step is kept; further requests are dropped. The pending step starts the clock after returning to IDLE.
- load = 1, any state, highest priority:
  - Abort to IDLE, next address ← start_adrs, checksum ← 0, valid_out ← 0, pending ← 0, wrap_out ← 0.
  - step_req is ignored while load = 1.
  - The first step after load falls reads start_adrs.
- Simultaneous step_req and the CAPTURE clock: the request becomes pending; nothing is lost.
- auto_en toggling mid-read: the read in flight completes normally. The divider resets when auto_en falls.
- reset mid-read: immediate return to reset values. Any RAM read in flight is discarded.
- Reads only; this block never drives write enable.

Decomposition:
- Shared package/header (alongside the existing constants include):
  - state encodings ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_CAPTURE = 2'd3
  - default SCAN_DIV
  - the sim-friendly SCAN_DIV override value, 8
- One natural sub-module, btn_edge_sync: 2-flop synchronizer plus falling-edge pulse generator. It is reusable for p_clock/clock buttons in the shell.

Test Plan:
- RAM model preloaded with mem[a] = a^8'h5A; reset; load start_adrs = 8'h10; one step_btn press → after 3 clocks shown_adrs = 8'h10, shown_data = 8'h4A, valid_out = 1, checksum_out = 8'h4A.
- Continue with 2 more presses → shown_adrs = 8'h12, shown_data = 8'h48, checksum_out = 8'h4A+8'h4B+8'h48 = 8'hDD.
- Load 8'hFE, press 3 times → reads FE, FF, 00; wrap_out pulses exactly once, in the FF capture clock; last shown_adrs = 8'h00.
- Three presses spaced 1 clock apart after sync, with RD_LAT = 3 → exactly two reads (the third request is dropped while one is pending); adrs_out holds stable through each WAIT.
- auto_en = 1, SCAN_DIV = 8, load 8'h00 → a new capture every 8 clocks, addresses 00, 01, 02…; step_btn presses have no effect.
- Assert load during WAIT → valid_out = 0, checksum_out = 0 next clock; the following step reads start_adrs. Assert reset during CAPTURE → all outputs 0 next clock.
